// File: rtl/noc_pkg.sv
// Shared NoC types and constants.
// Used by the router ingress channel and its VC FIFOs.
package noc_pkg;

  localparam int FLIT_W = 64;
  localparam int NUM_VC = 2;

  localparam logic VC0 = 1'b0;
  localparam logic VC1 = 1'b1;

  typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/router_input_channel_if.sv
// Link-side and switch-side signals of one router input port.
// master drives the link and grants; slave is the channel.
interface router_input_channel_if
  import noc_pkg::*;
#(
  parameter int WIDTH = FLIT_W
) ();

  logic             polarity;
  logic             send_in;
  logic [WIDTH-1:0] data_in;
  logic             ready_out;
  logic             req;
  logic [WIDTH-1:0] data_out;
  logic             grant;
  logic             drop_err;

  modport master (
    output polarity,
    output send_in,
    output data_in,
    output grant,
    input  ready_out,
    input  req,
    input  data_out,
    input  drop_err
  );

  modport slave (
    input  polarity,
    input  send_in,
    input  data_in,
    input  grant,
    output ready_out,
    output req,
    output data_out,
    output drop_err
  );

endinterface

// File: rtl/router_input_channel_vc_fifo.sv
// Single-clock first-word-fall-through FIFO for one VC.
// Writes when full and reads when empty are ignored.
module vc_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head
);

  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count
             + {{AW{1'b0}}, do_wr}
             - {{AW{1'b0}}, do_rd};
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_wr && !reset) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/router_input_channel.sv
// Router ingress: link fills VC[polarity], switch drains
// VC[~polarity]; a flit offered while full sets drop_err.
module router_input_channel
  import noc_pkg::*;
#(
  parameter  int WIDTH = FLIT_W,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic                   clk,
  input logic                   reset,
  router_input_channel_if.slave ch
);

  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  logic             wvc;
  logic             rvc;
  logic [NUM_VC-1:0] wr_en;
  logic [NUM_VC-1:0] rd_en;
  logic [NUM_VC-1:0] empty;
  logic [AW:0]      cnt  [NUM_VC];
  logic [WIDTH-1:0] head [NUM_VC];

  assign wvc = ch.polarity;
  assign rvc = ~ch.polarity;

  assign ch.ready_out = (cnt[wvc] != CNT_MAX);
  assign ch.req       = !empty[rvc];
  assign ch.data_out  = ch.req ? head[rvc] : '0;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign wr_en[v] = ch.send_in && ch.ready_out
                   && (wvc == 1'(v));
    assign rd_en[v] = ch.req && ch.grant
                   && (rvc == 1'(v));

    vc_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en[v]),
      .wr_data (ch.data_in),
      .rd_en   (rd_en[v]),
      .empty   (empty[v]),
      .count   (cnt[v]),
      .head    (head[v])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch.drop_err <= 1'b0;
    end else if (ch.send_in && !ch.ready_out) begin
      ch.drop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_router_input_channel.sv
// Scoreboard bench for router_input_channel: per-VC
// reference queues predict ready/req/data/drop each cycle.
module tb_router_input_channel;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  router_input_channel_if #(.WIDTH(64)) ch ();

  router_input_channel #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ch    (ch.slave)
  );

  int nchk  = 0;
  int nfail = 0;

  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  logic        mdrop;

  logic        last_req;
  logic        last_rdy;
  logic [63:0] last_data;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; samples at the falling edge.
  task automatic step(input logic        pol,
                      input logic        snd,
                      input logic [63:0] dat,
                      input logic        gnt);
    int          wsz;
    int          rsz;
    logic        exp_rdy;
    logic        exp_req;
    logic [63:0] exp_dat;
    ch.polarity = pol;
    ch.send_in  = snd;
    ch.data_in  = dat;
    ch.grant    = gnt;
    @(negedge clk);
    wsz     = pol ? q1.size() : q0.size();
    rsz     = pol ? q0.size() : q1.size();
    exp_rdy = (wsz != DEPTH);
    exp_req = (rsz != 0);
    exp_dat = 64'h0;
    if (exp_req) exp_dat = pol ? q0[0] : q1[0];
    check("ready_out", 64'(ch.ready_out), 64'(exp_rdy));
    check("req", 64'(ch.req), 64'(exp_req));
    check("data_out", ch.data_out, exp_dat);
    check("drop_err", 64'(ch.drop_err), 64'(mdrop));
    last_req  = ch.req;
    last_rdy  = ch.ready_out;
    last_data = ch.data_out;
    if (gnt && exp_req) begin
      if (pol) void'(q0.pop_front());
      else     void'(q1.pop_front());
    end
    if (snd && exp_rdy) begin
      if (pol) q1.push_back(dat);
      else     q0.push_back(dat);
    end else if (snd) begin
      mdrop = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Reset cycle with traffic offered, which must be ignored.
  task automatic do_reset();
    reset       = 1'b1;
    ch.polarity = 1'b0;
    ch.send_in  = 1'b1;
    ch.data_in  = 64'hDEAD_DEAD_DEAD_DEAD;
    ch.grant    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q0.delete();
    q1.delete();
    mdrop = 1'b0;
  endtask

  initial begin
    mdrop = 1'b0;
    do_reset();

    // 1: idle after reset
    for (int i = 0; i < 10; i++) step(i[0], 1'b0, 64'h0, 1'b0);

    // 2: single flit, one cycle latency
    step(1'b0, 1'b1, 64'hA5A5_0000_0000_0001, 1'b0);
    step(1'b1, 1'b0, 64'h0, 1'b1);
    check("t2_req", 64'(last_req), 64'h1);
    check("t2_data", last_data, 64'hA5A5_0000_0000_0001);
    step(1'b1, 1'b0, 64'h0, 1'b0);
    check("t2_req_after", 64'(last_req), 64'h0);

    // 3: fill VC1, overflow, drain in order
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 64'(i), 1'b0);
    step(1'b1, 1'b1, 64'h5, 1'b0);
    check("t3_full", 64'(last_rdy), 64'h0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, 64'h0, 1'b1);
      check("t3_drain", last_data, 64'(i));
    end
    step(1'b0, 1'b0, 64'h0, 1'b1);
    check("t3_empty", 64'(last_req), 64'h0);

    // 4: toggling polarity with send and grant every cycle
    do_reset();
    for (int i = 0; i < 20; i++)
      step(i[0], 1'b1, 64'h100 + 64'(i), 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    step(1'b1, 1'b0, 64'h0, 1'b1);
    check("t4_no_drop", 64'(mdrop), 64'h0);

    // 5: reset mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 64'h200 + 64'(i), 1'b0);
    do_reset();
    step(1'b0, 1'b0, 64'h0, 1'b0);
    check("t5_req", 64'(last_req), 64'h0);
    check("t5_ready", 64'(last_rdy), 64'h1);
    step(1'b1, 1'b1, 64'hBEEF, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    check("t5_first", last_data, 64'hBEEF);

    // 6: pointer wrap on VC0
    for (int i = 0; i < 3*DEPTH+1; i++) begin
      step(1'b0, 1'b1, 64'h10 + 64'(i), 1'b0);
      step(1'b1, 1'b0, 64'h0, 1'b1);
      check("t6_wrap", last_data, 64'h10 + 64'(i));
    end

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/router_input_channel.md
Name: router_input_channel

Overview:
Ingress stage of each mesh router port; feeds the switch that drives the output channel.
- Accepts 64-bit flits from the upstream link using a send/ready handshake.
- Buffers flits in two virtual-channel FIFOs (VC0, VC1), selected by the global polarity signal.
- Presents the head flit of the opposite VC to the switch/output channel, and pops it when granted.

Parameters:
WIDTH, 64, flit width in bits.
DEPTH, 4, entries per VC FIFO; power of two, minimum 2.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  reset, synchronous, active-high.
polarity  input  1  global phase: 0 = link writes VC0, switch reads VC1; 1 = link writes VC1, switch reads VC0.
send_in  input  1  upstream presents a valid flit.
data_in  input  WIDTH  upstream flit.
ready_out  output  1  this port can accept a flit this cycle.
req  output  1  head flit of the read-side VC is valid.
data_out  output  WIDTH  head flit of the read-side VC.
grant  input  1  downstream consumes data_out this cycle.
drop_err  output  1  sticky: a flit was presented while ready_out=0.

Behaviour:
- Write-side VC: wvc = polarity. Read-side VC: rvc = ~polarity. The two are always different, so a write and a read never target the same FIFO in the same cycle.
- ready_out = (count[wvc] != DEPTH). It is combinational from registered state and polarity only, with no dependence on send_in.
- Write: when send_in && ready_out, data_in is stored at wr_ptr[wvc] on the clock edge; wr_ptr[wvc] and count[wvc] increment.
- req = (count[rvc] != 0).
- data_out = req ? mem[rvc][rd_ptr[rvc]] : 0. It is combinational from registered state, so first-word fall-through applies.
- Pop: when req && grant, rd_ptr[rvc] increments and count[rvc] decrements on the clock edge.
- grant while req=0 is ignored; no state changes.
- Latency: a flit written in cycle N is visible on data_out in cycle N+1, once polarity has toggled so that its VC is the read side.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Counts are log2(DEPTH)+1 bits and saturate by construction; no overflow or underflow is possible.
- Full: ready_out=0. If send_in=1 while full, the flit is discarded, state is unchanged, and drop_err is set to 1 until reset.
- Empty: req=0 and data_out=0.
- Polarity toggles every cycle in normal operation. A static polarity is legal: one VC fills while the other drains.
- Reset, including reset asserted mid-transfer: all pointers and counts go to 0 and drop_err goes to 0, so req=0, data_out=0 and ready_out=1 on the following cycle. In-flight flits are discarded. FIFO memory contents are not reset.
- Any send_in or grant in a reset cycle is ignored.
- No bypass: a flit is never forwarded in the same cycle it arrives.

Decomposition:
- Shared package noc_pkg holds:
  - FLIT_W = 64
  - NUM_VC = 2
  - VC0 = 0, VC1 = 1
  - a flit typedef of FLIT_W bits
- Natural sub-module: vc_fifo, a single-clock FWFT FIFO with wr_en, rd_en, full, empty, count and head data.
  - Instantiated twice in router_input_channel.
  - The top level adds polarity steering, output muxing and drop_err.

Test Plan:
1. Reset, then idle -> ready_out=1, req=0, data_out=0, drop_err=0 for 10 cycles.
2. Polarity=0, send 0xA5A5_0000_0000_0001; polarity=1 next cycle, grant=1 -> in that cycle req=1 and data_out=0xA5A5_0000_0000_0001; the next cycle req=0.
3. Polarity held at 1, send 4 flits 0x1..0x4 (DEPTH=4) -> ready_out drops to 0 after the 4th write. A 5th send (0x5) sets drop_err=1 and is lost. Switching to polarity=0 with grant=1 drains exactly 0x1,0x2,0x3,0x4 in order.
4. Toggling polarity, with simultaneous send_in=1 and grant=1 every cycle over 20 flits -> in-order delivery, no drops, and each VC's count never exceeds 1.
5. Fill VC1 with 3 flits, assert reset for one cycle mid-stream -> next cycle count=0, req=0, ready_out=1, drop_err=0. The next flit 0xBEEF written into VC1 reads out first.
6. Wrap test: 3*DEPTH+1 write/pop pairs on VC0 -> pointers wrap and the data sequence 0x10..0x1C is preserved exactly.
